// File: rtl/valve_sequencer_pkg.sv
// Shared definitions for the valve bank sequencer: instruction fields,
// opcodes, delay units, FSM states, error codes and the delay scaling.
package valve_sequencer_pkg;

   localparam int INST_W = 13;
   localparam int CNT_W  = 16;

   localparam int OP_MSB   = 12;
   localparam int OP_LSB   = 10;
   localparam int IDX_MSB  = 9;
   localparam int IDX_LSB  = 6;
   localparam int N_MSB    = 9;
   localparam int N_LSB    = 4;
   localparam int UNIT_MSB = 3;
   localparam int UNIT_LSB = 1;
   localparam int VAL_BIT  = 0;

   localparam logic [2:0] OP_HALT  = 3'b000;
   localparam logic [2:0] OP_VALVE = 3'b001;
   localparam logic [2:0] OP_DELAY = 3'b010;

   localparam logic [2:0] UNIT_X1    = 3'b001;
   localparam logic [2:0] UNIT_X10   = 3'b010;
   localparam logic [2:0] UNIT_X100  = 3'b011;
   localparam logic [2:0] UNIT_X1000 = 3'b100;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_OPCODE = 2'b01;
   localparam logic [1:0] ERR_UNIT   = 2'b10;
   localparam logic [1:0] ERR_PC     = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_DELAY  = 3'd3,
      ST_HALTED = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   function automatic logic unit_legal(input logic [2:0] u);
      return (u == UNIT_X1) || (u == UNIT_X10) ||
             (u == UNIT_X100) || (u == UNIT_X1000);
   endfunction

   // Constant multipliers only: synthesises to shift/add, not a DSP.
   function automatic logic [CNT_W-1:0] delay_ticks(
      input logic [5:0] n,
      input logic [2:0] u
   );
      logic [CNT_W-1:0] n16;
      n16 = {{(CNT_W-6){1'b0}}, n};
      case (u)
         UNIT_X1:    delay_ticks = n16;
         UNIT_X10:   delay_ticks = n16 * 16'd10;
         UNIT_X100:  delay_ticks = n16 * 16'd100;
         UNIT_X1000: delay_ticks = n16 * 16'd1000;
         default:    delay_ticks = '0;
      endcase
   endfunction

endpackage

// File: rtl/valve_sequencer_delay_timer.sv
// Delay timer: tick prescaler plus 16-bit tick down counter.
// Ports: clk, rst_n, load/count/abort controls, n/unit operands, done pulse.
module valve_sequencer_delay_timer
   import valve_sequencer_pkg::*;
#(
   parameter int CLKS_PER_TICK = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       count,
   input  logic       abort,
   input  logic [5:0] n,
   input  logic [2:0] unit,
   output logic       done
);

   localparam int PRE_W =
      (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST =
      PRE_W'(CLKS_PER_TICK - 1);

   logic [PRE_W-1:0] presc;
   logic [CNT_W-1:0] cnt;
   logic             wrap;

   assign wrap = (presc == PRE_LAST);

   // Done fires on the wrap that would take cnt from 1 to 0, so the
   // owner leaves DELAY after exactly cnt*CLKS_PER_TICK clocks.
   assign done = count && wrap && (cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         cnt   <= '0;
      end else if (abort) begin
         presc <= '0;
         cnt   <= '0;
      end else if (load) begin
         presc <= '0;
         cnt   <= delay_ticks(n, unit);
      end else if (count) begin
         if (wrap) begin
            presc <= '0;
            cnt   <= cnt - 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

endmodule

// File: rtl/valve_sequencer.sv
// Valve bank program sequencer: fetches from an external async ROM,
// runs VALVE/DELAY/HALT and drives a registered valve vector.
// Ports: clk, rst_n, start, abort, inst_addr/inst_data (ROM),
//        valve_state, busy, halted, error, err_code.
module valve_sequencer
   import valve_sequencer_pkg::*;
#(
   parameter int ADDR_W        = 8,
   parameter int MEM_DEPTH     = 100,
   parameter int NUM_VALVES    = 16,
   parameter int CLKS_PER_TICK = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADDR_W-1:0]     inst_addr,
   input  logic [INST_W-1:0]     inst_data,
   output logic [NUM_VALVES-1:0] valve_state,
   output logic                  busy,
   output logic                  halted,
   output logic                  error,
   output logic [1:0]            err_code
);

   localparam logic [31:0] DEPTH = MEM_DEPTH;
   localparam logic [31:0] NV    = NUM_VALVES;

   state_t                state;
   state_t                state_nx;
   logic [ADDR_W-1:0]     pc;
   logic [INST_W-1:0]     ir;
   logic [NUM_VALVES-1:0] valves;
   logic [1:0]            ec;

   logic [2:0] op;
   logic [3:0] idx;
   logic       val;
   logic [5:0] n;
   logic [2:0] unit;
   logic       is_halt;
   logic       is_valve;
   logic       is_delay;
   logic       unit_ok;
   logic       n_zero;
   logic       idx_ok;
   logic       pc_bad;
   logic       tmr_load;
   logic       tmr_count;
   logic       tmr_done;

   assign op       = ir[OP_MSB:OP_LSB];
   assign idx      = ir[IDX_MSB:IDX_LSB];
   assign val      = ir[VAL_BIT];
   assign n        = ir[N_MSB:N_LSB];
   assign unit     = ir[UNIT_MSB:UNIT_LSB];
   assign is_halt  = (op == OP_HALT);
   assign is_valve = (op == OP_VALVE);
   assign is_delay = (op == OP_DELAY);
   assign unit_ok  = unit_legal(unit);
   assign n_zero   = (n == 6'd0);
   assign idx_ok   = (32'(idx) < NV);
   assign pc_bad   = (32'(pc) >= DEPTH);

   assign inst_addr   = pc;
   assign valve_state = valves;
   assign err_code    = ec;

   valve_sequencer_delay_timer #(
      .CLKS_PER_TICK(CLKS_PER_TICK)
   ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (tmr_load),
      .count(tmr_count),
      .abort(abort),
      .n    (n),
      .unit (unit),
      .done (tmr_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // An illegal unit is reported even when N is zero.
   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
               if (start) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
               state_nx = pc_bad ? ST_ERROR : ST_EXEC;
            end
            ST_EXEC: begin
               unique case (1'b1)
                  is_valve: state_nx = ST_FETCH;
                  is_delay: begin
                     if (!unit_ok)    state_nx = ST_ERROR;
                     else if (n_zero) state_nx = ST_FETCH;
                     else             state_nx = ST_DELAY;
                  end
                  is_halt:  state_nx = ST_HALTED;
                  default:  state_nx = ST_ERROR;
               endcase
            end
            ST_DELAY: begin
               if (tmr_done) state_nx = ST_FETCH;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = 1'b0;
      halted    = 1'b0;
      error     = 1'b0;
      tmr_load  = 1'b0;
      tmr_count = 1'b0;
      unique case (state)
         ST_FETCH: busy = 1'b1;
         ST_EXEC: begin
            busy     = 1'b1;
            tmr_load = is_delay && unit_ok && !n_zero;
         end
         ST_DELAY: begin
            busy      = 1'b1;
            tmr_count = 1'b1;
         end
         ST_HALTED: halted = 1'b1;
         ST_ERROR:  error  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= '0;
         ir     <= '0;
         valves <= '0;
         ec     <= ERR_NONE;
      end else if (abort) begin
         pc     <= '0;
         valves <= '0;
         ec     <= ERR_NONE;
      end else begin
         unique case (state)
            ST_IDLE, ST_HALTED: begin
               if (start) pc <= '0;
            end
            ST_ERROR: begin
               if (start) begin
                  pc <= '0;
                  ec <= ERR_NONE;
               end
            end
            ST_FETCH: begin
               if (pc_bad) begin
                  ec     <= ERR_PC;
                  valves <= '0;
               end else begin
                  ir <= inst_data;
               end
            end
            ST_EXEC: begin
               unique case (1'b1)
                  is_valve: begin
                     if (idx_ok) valves[idx] <= val;
                     pc <= pc + 1'b1;
                  end
                  is_delay: begin
                     if (!unit_ok) begin
                        ec     <= ERR_UNIT;
                        valves <= '0;
                     end else if (n_zero) begin
                        pc <= pc + 1'b1;
                     end
                  end
                  is_halt: ;
                  default: begin
                     ec     <= ERR_OPCODE;
                     valves <= '0;
                  end
               endcase
            end
            ST_DELAY: begin
               if (tmr_done) pc <= pc + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_valve_sequencer.sv
// Self-checking bench for valve_sequencer with CLKS_PER_TICK=4.
// Ports: none (drives two DUTs, MEM_DEPTH 100 and 3, from one ROM).
module tb_valve_sequencer;

   localparam int TICK = 4;
   localparam int MAXC = 8192;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  addr_a, addr_b;
   logic [12:0] data_a, data_b;
   logic [15:0] vs_a, vs_b;
   logic        busy_a, busy_b, halted_a, halted_b, error_a, error_b;
   logic [1:0]  ec_a, ec_b;
   logic [12:0] stat_a, stat_b;
   logic [12:0] rom [0:255];

   assign data_a = rom[addr_a];
   assign data_b = rom[addr_b];
   assign stat_a = {addr_a, busy_a, halted_a, error_a, ec_a};
   assign stat_b = {addr_b, busy_b, halted_b, error_b, ec_b};

   always #5 clk = ~clk;

   valve_sequencer #(
      .ADDR_W(8), .MEM_DEPTH(100), .NUM_VALVES(16), .CLKS_PER_TICK(TICK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .inst_addr(addr_a), .inst_data(data_a), .valve_state(vs_a),
      .busy(busy_a), .halted(halted_a), .error(error_a), .err_code(ec_a)
   );

   valve_sequencer #(
      .ADDR_W(8), .MEM_DEPTH(3), .NUM_VALVES(16), .CLKS_PER_TICK(TICK)
   ) dut_small (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .inst_addr(addr_b), .inst_data(data_b), .valve_state(vs_b),
      .busy(busy_b), .halted(halted_b), .error(error_b), .err_code(ec_b)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_v [0:MAXC-1];
   logic [12:0] exp_s [0:MAXC-1];
   int          exp_len;
   logic [15:0] end_v;
   logic [15:0] cur_v = 16'h0;

   function automatic logic [12:0] vi(input int idx, input bit v);
      return {3'b001, 4'(idx), 5'b0, v};
   endfunction

   function automatic logic [12:0] di(input int n, input int u);
      return {3'b010, 6'(n), 3'(u), 1'b0};
   endfunction

   function automatic logic [12:0] st(input int pc, input bit b,
      input bit h, input bit e, input logic [1:0] ec);
      return {8'(pc), b, h, e, ec};
   endfunction

   function automatic int mult(input logic [2:0] u);
      case (u)
         3'd1: return 1;
         3'd2: return 10;
         3'd3: return 100;
         3'd4: return 1000;
         default: return 0;
      endcase
   endfunction

   // Instruction-level interpreter: each instruction costs a fetch and
   // an execute cycle, a delay adds N*mult*TICK cycles. Index k counts
   // cycles after the edge that samples start.
   task automatic model(input logic [15:0] v0, input int depth);
      int t, pc, d, m;
      logic [15:0] v;
      logic [12:0] w, term;
      bit done;
      t = 1; pc = 0; v = v0; done = 0; term = '0;
      while (!done && t < MAXC - 8) begin
         if (pc >= depth) begin
            exp_v[t] = v; exp_s[t] = st(pc, 1, 0, 0, 2'd0); t++;
            v = '0; term = st(pc, 0, 0, 1, 2'd3); done = 1;
         end else begin
            w = rom[pc];
            for (int i = 0; i < 2; i++) begin
               exp_v[t+i] = v; exp_s[t+i] = st(pc, 1, 0, 0, 2'd0);
            end
            t += 2;
            case (w[12:10])
               3'd0: begin term = st(pc, 0, 1, 0, 2'd0); done = 1; end
               3'd1: begin v[w[9:6]] = w[0]; pc++; end
               3'd2: begin
                  m = mult(w[3:1]);
                  if (m == 0) begin
                     v = '0; term = st(pc, 0, 0, 1, 2'd2); done = 1;
                  end else begin
                     d = int'(w[9:4]) * m * TICK;
                     for (int i = 0; i < d && t < MAXC - 8; i++) begin
                        exp_v[t] = v; exp_s[t] = st(pc, 1, 0, 0, 2'd0); t++;
                     end
                     pc++;
                  end
               end
               default: begin
                  v = '0; term = st(pc, 0, 0, 1, 2'd1); done = 1;
               end
            endcase
         end
      end
      if (done) begin
         for (int i = 0; i < 3; i++) begin
            exp_v[t] = v; exp_s[t] = term; t++;
         end
      end
      exp_len = t;
      end_v = v;
   endtask

   task automatic check(input string tag, input int k,
      input logic [15:0] ov, input logic [15:0] ev,
      input logic [12:0] os, input logic [12:0] es);
      vectors++;
      assert (ov === ev) else begin
         miscompares++;
         $error("FAIL %s.valves k=%0d got %h exp %h", tag, k, ov, ev);
      end
      vectors++;
      assert (os === es) else begin
         miscompares++;
         $error("FAIL %s.status k=%0d got %h exp %h", tag, k, os, es);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of cycle min(lim,len).
   task automatic run(input int sel, input logic [15:0] v0,
      input int depth, input int lim, input string tag);
      int n;
      model(v0, depth);
      n = (lim > 0 && lim < exp_len) ? lim : exp_len;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k < n; k++) begin
         if (sel == 0) check(tag, k, vs_a, exp_v[k], stat_a, exp_s[k]);
         else          check(tag, k, vs_b, exp_v[k], stat_b, exp_s[k]);
         @(posedge clk); #1;
      end
      if (sel == 0) cur_v = end_v;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cur_v = '0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 13'h0;
   endtask

   initial begin
      int len, kind;
      clear_rom();
      repeat (3) @(posedge clk);
      #1;
      check("reset", 0, vs_a, 16'h0, stat_a, 13'h0);
      check("reset_s", 0, vs_b, 16'h0, stat_b, 13'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      rom[0] = vi(1, 1); rom[1] = vi(1, 0); rom[2] = 13'h0;
      run(0, cur_v, 100, 0, "t1");
      check("t1.end", 0, vs_a, 16'h0000, stat_a, st(2, 0, 1, 0, 2'd0));

      clear_rom();
      rom[0] = di(3, 1); rom[1] = 13'h0;
      run(0, cur_v, 100, 0, "t2a");
      rom[0] = di(1, 2);
      run(0, cur_v, 100, 0, "t2b");
      rom[0] = di(0, 1); rom[1] = vi(7, 1); rom[2] = 13'h0;
      run(0, cur_v, 100, 0, "t2c");
      rom[0] = di(1, 3); rom[1] = vi(6, 1); rom[2] = di(1, 4);
      rom[3] = vi(7, 0); rom[4] = 13'h0;
      run(0, cur_v, 100, 0, "t2d");

      clear_rom();
      rom[0]  = vi(1, 1); rom[1]  = di(2, 1);
      rom[2]  = vi(3, 1); rom[3]  = di(1, 2);
      rom[4]  = vi(0, 1); rom[5]  = di(3, 1);
      rom[6]  = vi(2, 1); rom[7]  = di(0, 1);
      rom[8]  = vi(1, 0); rom[9]  = di(1, 1);
      rom[10] = vi(3, 0); rom[11] = di(2, 1);
      rom[12] = vi(0, 0); rom[13] = di(1, 2);
      rom[14] = vi(2, 0); rom[15] = di(1, 1);
      rom[16] = 13'h0;
      run(0, cur_v, 100, 0, "t3");

      clear_rom();
      rom[0] = vi(5, 1); rom[1] = 13'h0;
      run(0, cur_v, 100, 0, "t4a");
      rom[0] = 13'h1C00;
      run(0, cur_v, 100, 0, "t4b");
      rom[0] = di(2, 7);
      run(0, cur_v, 100, 0, "t4c");
      rom[0] = vi(4, 1); rom[1] = 13'h0;
      run(0, cur_v, 100, 0, "t4d");

      for (int r = 0; r < 8; r++) begin
         clear_rom();
         len = $urandom_range(3, 10);
         for (int i = 0; i < len; i++) begin
            kind = $urandom_range(0, 7);
            if (kind < 6)
               rom[i] = vi($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            else
               rom[i] = di($urandom_range(0, 3), $urandom_range(1, 2));
         end
         if (r == 5) rom[len] = {3'($urandom_range(3, 7)), 10'($urandom)};
         else        rom[len] = 13'h0;
         run(0, cur_v, 100, 0, "rnd");
      end

      do_reset();
      clear_rom();
      rom[0] = vi(0, 1); rom[1] = vi(3, 1); rom[2] = di(10, 1);
      rom[3] = 13'h0;
      run(0, cur_v, 100, 10, "t5");
      check("t5.pre", 10, vs_a, 16'h0009, stat_a, st(2, 1, 0, 0, 2'd0));
      abort = 1'b1;
      @(posedge clk); #1;
      check("t5.abort", 0, vs_a, 16'h0, stat_a, 13'h0);
      start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      check("t5.both", 0, vs_a, 16'h0, stat_a, 13'h0);

      do_reset();
      clear_rom();
      rom[0] = vi(1, 1); rom[1] = vi(2, 1); rom[2] = vi(3, 1);
      rom[3] = 13'h0;
      run(1, 16'h0, 3, 0, "t6ovr");
      check("t6.ovr", 0, vs_b, 16'h0, stat_b, st(3, 0, 0, 1, 2'd3));

      do_reset();
      clear_rom();
      rom[0] = vi(4, 1); rom[1] = di(5, 1); rom[2] = 13'h0;
      run(0, cur_v, 100, 10, "t6rst");
      check("t6.pre", 10, vs_a, 16'h0010, stat_a, st(1, 1, 0, 0, 2'd0));
      #2 rst_n = 1'b0;
      #1;
      check("t6.async", 0, vs_a, 16'h0, stat_a, 13'h0);
      check("t6.async_s", 0, vs_b, 16'h0, stat_b, 13'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("t6.after", 0, vs_a, 16'h0, stat_a, 13'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
